commit_arbiter: RTL and testbench

//  Shares the single commit port of the scalar unit's commit stage between NUM_SRC commit producers
//  (e.g. scalar pipe, vector commit aggregator, load/store unit). Round-robin arbitration feeds a
//  one-entry output register held until granted by the commit stage. Full throughput: one commit/cycle.

---
 rtl/commit_arbiter_if.sv | 37 +++
 rtl/commit_arbiter.sv | 97 +++++++++
 tb/tb_commit_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/commit_arbiter_if.sv
// commit_arbiter_if: bundle between commit producers, commit stage and commit_arbiter.
// COMMIT_ORDER_CHECK_EN adds the order_wait status signal.
interface commit_arbiter_if #(
   parameter int NUM_SRC = 3,
   parameter int ISSUE_W = 8
);
   localparam int WIDTH_SRC = $clog2(NUM_SRC);
   logic                              flush;
   logic [NUM_SRC-1:0]                req;
   logic [NUM_SRC-1:0][ISSUE_W-1:0]   issue_no;
   logic [NUM_SRC-1:0]                grant;
   logic                              commit_req;
   logic [ISSUE_W-1:0]                commit_no;
   logic [WIDTH_SRC-1:0]              commit_src;
   logic                              commit_grant;
   logic                              busy;
`ifdef COMMIT_ORDER_CHECK_EN
   logic                              order_wait;
   modport master (
      output flush, req, issue_no, commit_grant,
      input  grant, commit_req, commit_no, commit_src, busy, order_wait
   );
   modport slave (
      input  flush, req, issue_no, commit_grant,
      output grant, commit_req, commit_no, commit_src, busy, order_wait
   );
`else
   modport master (
      output flush, req, issue_no, commit_grant,
      input  grant, commit_req, commit_no, commit_src, busy
   );
   modport slave (
      input  flush, req, issue_no, commit_grant,
      output grant, commit_req, commit_no, commit_src, busy
   );
`endif
endinterface

// File: rtl/commit_arbiter.sv
// commit_arbiter: round-robin share of the single commit port among NUM_SRC producers via a one-entry output register.
// Optional COMMIT_ORDER_CHECK_EN only lets through the source carrying the next expected commit number.
module commit_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int ISSUE_W = 8
) (
   input logic             clock,
   input logic             reset,
   commit_arbiter_if.slave bus
);
   localparam int WIDTH_SRC = $clog2(NUM_SRC);
   typedef logic [ISSUE_W-1:0] issue_no_t;
   logic [NUM_SRC-1:0]   elig;
   logic                 ld;
   logic                 found;
   int                   cand;
   logic [WIDTH_SRC-1:0] win;
   logic [WIDTH_SRC-1:0] ptr_q, ptr_d;
   logic [WIDTH_SRC-1:0] src_q, src_d;
   logic                 commit_req_q, commit_req_d;
   issue_no_t            commit_no_q, commit_no_d;
`ifdef COMMIT_ORDER_CHECK_EN
   issue_no_t            next_no_q, next_no_d;
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_SRC; i++) elig[i] = bus.req[i] & (bus.issue_no[i] == next_no_q);
   end
   assign bus.order_wait = reset & ld & (|bus.req) & ~(|elig);
`else
   assign elig = bus.req;
`endif
   assign ld = ~commit_req_q | bus.commit_grant;
   // Scan downward so the last hit is the closest one at or after ptr_q.
   always_comb begin
      win = '0;
      found = 1'b0;
      cand = 0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         cand = int'(ptr_q) + k;
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         if (elig[cand]) begin
            win = WIDTH_SRC'(cand);
            found = 1'b1;
         end
      end
   end
   assign bus.grant      = (reset & ld & ~bus.flush & found) ? (NUM_SRC'(1) << win) : '0;
   assign bus.busy       = commit_req_q | (|bus.req);
   assign bus.commit_req = commit_req_q;
   assign bus.commit_no  = commit_no_q;
   assign bus.commit_src = src_q;
   always_comb begin
      commit_req_d = commit_req_q;
      commit_no_d  = commit_no_q;
      src_d        = src_q;
      ptr_d        = ptr_q;
`ifdef COMMIT_ORDER_CHECK_EN
      next_no_d    = next_no_q;
`endif
      if (bus.flush) begin
         commit_req_d = 1'b0;
         ptr_d        = '0;
`ifdef COMMIT_ORDER_CHECK_EN
         next_no_d    = '0;
`endif
      end else if (|bus.grant) begin
         commit_req_d = 1'b1;
         commit_no_d  = bus.issue_no[win];
         src_d        = win;
         ptr_d        = (win == WIDTH_SRC'(NUM_SRC - 1)) ? '0 : win + 1'b1;
`ifdef COMMIT_ORDER_CHECK_EN
         next_no_d    = next_no_q + 1'b1;
`endif
      end else if (bus.commit_grant) begin
         commit_req_d = 1'b0;
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         commit_req_q <= 1'b0;
         commit_no_q  <= '0;
         src_q        <= '0;
         ptr_q        <= '0;
`ifdef COMMIT_ORDER_CHECK_EN
         next_no_q    <= '0;
`endif
      end else begin
         commit_req_q <= commit_req_d;
         commit_no_q  <= commit_no_d;
         src_q        <= src_d;
         ptr_q        <= ptr_d;
`ifdef COMMIT_ORDER_CHECK_EN
         next_no_q    <= next_no_d;
`endif
      end
   end
endmodule

// File: tb/tb_commit_arbiter.sv
// tb_commit_arbiter: directed scenarios plus randomized traffic against a behavioural commit-port model.
module tb_commit_arbiter;
   localparam int N = 3;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   commit_arbiter_if #(.NUM_SRC(N), .ISSUE_W(W)) bus ();
   commit_arbiter #(.NUM_SRC(N), .ISSUE_W(W)) dut (.clock(clk), .reset(rst_n), .bus(bus.slave));
   int n_cmp = 0;
   int n_err = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   logic         m_req;
   logic [W-1:0] m_no;
   int           m_src, m_ptr;
   logic [W-1:0] m_next;
   logic         pend [N];
   logic [W-1:0] num [N];
   logic [W-1:0] issue_ctr;
   initial begin
      bus.req = '0;
      bus.flush = 1'b0;
      bus.commit_grant = 1'b1;
      bus.issue_no[0] = 8'd10;
      bus.issue_no[1] = 8'd20;
      bus.issue_no[2] = 8'd30;
      bus.req = 3'b111;
      repeat (2) @(negedge clk);
      #1;
      check("rst_grant", bus.grant, 0);
      check("rst_creq", bus.commit_req, 0);
      check("rst_no", bus.commit_no, 0);
      check("rst_src", bus.commit_src, 0);
`ifndef COMMIT_ORDER_CHECK_EN
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("rr_grant", bus.grant, 1 << (k % 3));
         if (k > 0) begin
            check("rr_creq", bus.commit_req, 1);
            check("rr_no", bus.commit_no, 10 * ((k - 1) % 3 + 1));
            check("rr_src", bus.commit_src, (k - 1) % 3);
         end
         @(negedge clk);
         #1;
      end
      bus.req = 3'b010;
      bus.issue_no[1] = 8'd5;
      #1;
      check("st_grant1", bus.grant, 3'b010);
      @(negedge clk);
      bus.commit_grant = 1'b0;
      bus.req = 3'b101;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("st_grant", bus.grant, 0);
         check("st_creq", bus.commit_req, 1);
         check("st_no", bus.commit_no, 5);
         @(negedge clk);
      end
      bus.commit_grant = 1'b1;
      #1;
      check("st_release", bus.grant, 3'b100);
      @(negedge clk);
      #1;
      check("st_no2", bus.commit_no, 30);
      check("st_src2", bus.commit_src, 2);
      bus.issue_no[0] = 8'd7;
      bus.req = 3'b001;
      #1;
      check("fl_load", bus.grant, 3'b001);
      @(negedge clk);
      bus.flush = 1'b1;
      bus.req = 3'b100;
      bus.commit_grant = 1'b0;
      #1;
      check("fl_grant", bus.grant, 0);
      check("fl_held", bus.commit_no, 7);
      @(negedge clk);
      bus.flush = 1'b0;
      bus.req = 3'b111;
      #1;
      check("fl_creq", bus.commit_req, 0);
      check("fl_ptr0", bus.grant, 3'b001);
`endif
      @(negedge clk);
      bus.req = '0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      bus.issue_no[0] = 8'd0;
      bus.issue_no[1] = 8'd1;
      bus.req = 3'b011;
      bus.commit_grant = 1'b1;
      @(negedge clk);
      bus.req = 3'b010;
      @(negedge clk);
      bus.req = '0;
      #1;
      check("ar_pre_creq", bus.commit_req, 1);
      check("ar_pre_no", bus.commit_no, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_creq", bus.commit_req, 0);
      check("ar_no", bus.commit_no, 0);
      check("ar_grant", bus.grant, 0);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef COMMIT_ORDER_CHECK_EN
      bus.issue_no[0] = 8'd1;
      bus.issue_no[2] = 8'd0;
      bus.req = 3'b101;
      #1;
      check("ord_first", bus.grant, 3'b100);
      @(negedge clk);
      bus.req = 3'b001;
      #1;
      check("ord_second", bus.grant, 3'b001);
      @(negedge clk);
      bus.req = 3'b010;
      bus.issue_no[1] = 8'd3;
      #1;
      check("ord_block", bus.grant, 0);
      check("ord_wait", bus.order_wait, 1);
      @(negedge clk);
`endif
      bus.req = '0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      m_req = 1'b0;
      m_no = '0;
      m_src = 0;
      m_ptr = 0;
      m_next = '0;
      issue_ctr = '0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0;
         num[i] = '0;
      end
      for (int c = 0; c < 1500; c++) begin
         int best, bd, eg;
         logic fl, cg, ld, any_req, any_elig;
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               num[i] = issue_ctr;
               issue_ctr = issue_ctr + 1'b1;
            end
         fl = ($urandom_range(0, 19) == 0);
         cg = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            bus.req[i] = pend[i];
            bus.issue_no[i] = num[i];
         end
         bus.flush = fl;
         bus.commit_grant = cg;
         #1;
         best = -1;
         bd = N;
         any_req = 1'b0;
         any_elig = 1'b0;
         for (int i = 0; i < N; i++) begin
            logic e;
            e = pend[i];
`ifdef COMMIT_ORDER_CHECK_EN
            e = e && (num[i] == m_next);
`endif
            any_req |= pend[i];
            any_elig |= e;
            if (e && ((i - m_ptr + N) % N) < bd) begin
               bd = (i - m_ptr + N) % N;
               best = i;
            end
         end
         ld = !m_req || cg;
         eg = (ld && !fl && best >= 0) ? (1 << best) : 0;
         check("rnd_grant", bus.grant, eg);
         check("rnd_creq", bus.commit_req, m_req);
         check("rnd_no", bus.commit_no, m_no);
         check("rnd_src", bus.commit_src, m_src);
         check("rnd_busy", bus.busy, m_req || any_req);
`ifdef COMMIT_ORDER_CHECK_EN
         check("rnd_wait", bus.order_wait, any_req && !any_elig && ld);
`endif
         if (fl) begin
            m_req = 1'b0;
            m_ptr = 0;
            m_next = '0;
            issue_ctr = '0;
            for (int i = 0; i < N; i++) pend[i] = 1'b0;
         end else if (eg != 0) begin
            m_req = 1'b1;
            m_no = num[best];
            m_src = best;
            m_ptr = (best + 1) % N;
            m_next = m_next + 1'b1;
            pend[best] = 1'b0;
         end else if (cg) begin
            m_req = 1'b0;
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
